// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-access controllers.
//
// Contents:
//   state_t      - sequencer states used by spi_frame_arbiter
//   INSTR_RW_BIT - bit position of the read/write flag in the instruction byte
//   ADDR_W       - register address width carried in the instruction byte
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SEND,
        WAIT_RX,
        DONE,
        GAP
    } state_t;

    localparam int INSTR_RW_BIT = 7;
    localparam int ADDR_W       = 7;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker shared by the bus controllers.
//
// Ports:
//   req    [N-1:0]     - request vector
//   rr_ptr [PTR_W-1:0] - index searched first; the search wraps modulo N
//   gnt    [N-1:0]     - one-hot winner, all zero when no request is set
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the requests starting at rr_ptr; the first set one wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Round-robin sequencer sharing one byte-oriented SPI master engine between
// NUM_REQ register-access requesters. Each grant becomes one frame of an
// instruction byte {rw, addr} followed by DATA_BYTES write bytes (MSB first),
// offered through a show-ahead source (spi_data / spi_empty / spi_rdreq).
// Returned bytes 1..DATA_BYTES are assembled into rdata; byte 0 is dropped.
//
// Ports:
//   sys_clk, n_rst           - clock, asynchronous active-low reset
//   req, req_rw              - per-requester request and read(1)/write(0)
//   req_addr, req_wdata      - per-requester address and write data
//   gnt, done, err, rdata    - grant, completion pulse, timeout flag, read data
//   busy                     - sequencer not idle
//   spi_data, spi_empty      - byte offered to the engine, nothing pending
//   spi_rdreq                - engine consumed spi_data
//   spi_rx_byte/spi_rx_valid - byte received by the engine and its strobe
module spi_frame_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BYTES = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                             sys_clk,
    input  logic                             n_rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]        req_addr,
    input  logic [NUM_REQ*DATA_BYTES*8-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               done,
    output logic                             err,
    output logic [DATA_BYTES*8-1:0]          rdata,
    output logic                             busy,
    output logic [7:0]                       spi_data,
    output logic                             spi_empty,
    input  logic                             spi_rdreq,
    input  logic [7:0]                       spi_rx_byte,
    input  logic                             spi_rx_valid
);

    localparam int DW          = DATA_BYTES * 8;
    localparam int PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FRAME_BYTES = DATA_BYTES + 1;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0] win_idx;
    logic             sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic [7:0]       instr;
    logic [DW-1:0]    wshift;
    logic [DW-1:0]    rx_shift;
    logic [DW-1:0]    rx_shift_nxt;
    logic [2:0]       byte_idx;
    logic [2:0]       rx_cnt;
    logic [2:0]       rx_cnt_nxt;
    logic [7:0]       tmo_cnt;
    logic [7:0]       gap_cnt;
    logic             rdreq_take;
    logic             rx_take;
    logic             timeout_hit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt)
    );

    // Mux out the winner's fields so ARB can latch them in one cycle.
    always_comb begin
        win_idx   = '0;
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_idx   = PTR_W'(i);
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
        instr                = '0;
        instr[INSTR_RW_BIT]  = sel_rw;
        instr[ADDR_W-1:0]    = sel_addr;
    end

    // Engine handshakes only count in the states that own the engine. The
    // receive counter saturates at a full frame so extra strobes are dropped.
    always_comb begin
        rdreq_take   = spi_rdreq && (state == SEND);
        rx_take      = spi_rx_valid && ((state == SEND) || (state == WAIT_RX))
                       && (rx_cnt != 3'(FRAME_BYTES));
        rx_cnt_nxt   = rx_cnt + 3'(rx_take);
        rx_shift_nxt = rx_shift;
        if (rx_take && (rx_cnt != 3'd0)) begin
            rx_shift_nxt = (rx_shift << 8) | DW'(spi_rx_byte);
        end
        timeout_hit  = !(spi_rdreq || spi_rx_valid) && (tmo_cnt == 8'(TIMEOUT - 1));
    end

    // Frame sequencer with registered outputs. The write data is held in a
    // shift register so the next byte is always at the top.
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            spi_data  <= '0;
            spi_empty <= 1'b1;
            wshift    <= '0;
            rx_shift  <= '0;
            byte_idx  <= '0;
            rx_cnt    <= '0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    // A request withdrawn before the pick simply returns to IDLE.
                    if (|arb_gnt) begin
                        gnt       <= arb_gnt;
                        rr_ptr    <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                        spi_data  <= instr;
                        wshift    <= sel_wdata;
                        spi_empty <= 1'b0;
                        byte_idx  <= '0;
                        rx_cnt    <= '0;
                        rx_shift  <= '0;
                        tmo_cnt   <= '0;
                        state     <= SEND;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SEND, WAIT_RX: begin
                    rx_cnt   <= rx_cnt_nxt;
                    rx_shift <= rx_shift_nxt;
                    if (spi_rdreq || spi_rx_valid) begin
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                    if (timeout_hit) begin
                        state     <= DONE;
                        done      <= gnt;
                        err       <= 1'b1;
                        gnt       <= '0;
                        spi_empty <= 1'b1;
                        tmo_cnt   <= '0;
                    end else if ((state == WAIT_RX) && (rx_cnt_nxt == 3'(FRAME_BYTES))) begin
                        state   <= DONE;
                        done    <= gnt;
                        err     <= 1'b0;
                        gnt     <= '0;
                        rdata   <= rx_shift_nxt;
                        tmo_cnt <= '0;
                    end else if (rdreq_take) begin
                        if (byte_idx == 3'(DATA_BYTES)) begin
                            spi_empty <= 1'b1;
                            state     <= WAIT_RX;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            spi_data <= wshift[DW-1 -: 8];
                            wshift   <= wshift << 8;
                        end
                    end
                end
                DONE: begin
                    state   <= GAP;
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Self-checking bench for spi_frame_arbiter. The bench plays both the
// requesters and the SPI byte engine, and predicts grants, transmitted bytes
// and returned data from a small behavioural model.
module tb_spi_frame_arbiter;

    localparam int N   = 4;
    localparam int D   = 2;
    localparam int DW  = D * 8;
    localparam int GAP = 2;
    localparam int TMO = 255;

    logic                sys_clk = 1'b0;
    logic                n_rst;
    logic [N-1:0]        req;
    logic [N-1:0]        req_rw;
    logic [N*7-1:0]      req_addr;
    logic [N*DW-1:0]     req_wdata;
    logic [N-1:0]        gnt;
    logic [N-1:0]        done;
    logic                err;
    logic [DW-1:0]       rdata;
    logic                busy;
    logic [7:0]          spi_data;
    logic                spi_empty;
    logic                spi_rdreq;
    logic [7:0]          spi_rx_byte;
    logic                spi_rx_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int            model_ptr = 0;
    logic [DW-1:0] exp_rdata = '0;
    logic          f_rw    [N];
    logic [6:0]    f_addr  [N];
    logic [DW-1:0] f_wdata [N];

    spi_frame_arbiter #(
        .NUM_REQ    (N),
        .DATA_BYTES (D),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .sys_clk      (sys_clk),
        .n_rst        (n_rst),
        .req          (req),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .busy         (busy),
        .spi_data     (spi_data),
        .spi_empty    (spi_empty),
        .spi_rdreq    (spi_rdreq),
        .spi_rx_byte  (spi_rx_byte),
        .spi_rx_valid (spi_rx_valid)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Round-robin rule: first set request at or after p, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            f_rw[i]    = 1'($urandom);
            f_addr[i]  = 7'($urandom);
            f_wdata[i] = DW'($urandom);
        end
    endtask

    task automatic load_fields();
        for (int i = 0; i < N; i++) begin
            req_rw[i]              = f_rw[i];
            req_addr[i*7 +: 7]     = f_addr[i];
            req_wdata[i*DW +: DW]  = f_wdata[i];
        end
    endtask

    task automatic settle();
        repeat (GAP + 4) tick();
    endtask

    task automatic wait_grant(input int owner, output int waited, output bit empty_ok);
        logic [N-1:0] exp_g;
        exp_g        = '0;
        exp_g[owner] = 1'b1;
        waited       = 0;
        empty_ok     = 1'b1;
        while (gnt === '0 && waited < 40) begin
            if (spi_empty !== 1'b1) empty_ok = 1'b0;
            tick();
            waited++;
        end
        n_cmp++;
        if (gnt !== exp_g) begin
            n_fail++;
            $display("[TB] FAIL grant: got %b expected %b", gnt, exp_g);
        end
        model_ptr = (owner + 1) % N;
    endtask

    // Engine emulation for one complete frame owned by 'owner'.
    task automatic run_frame(input int owner, input logic [8*(D+1)-1:0] rx_all,
                             input bit overlap, input bit drop,
                             output int waited, output bit empty_ok);
        logic [7:0]   exp_byte;
        logic [N-1:0] exp_g;
        int           j0;
        exp_g        = '0;
        exp_g[owner] = 1'b1;
        load_fields();
        wait_grant(owner, waited, empty_ok);
        // Scramble the request fields: the frame must use the latched copy.
        req_addr  = 28'($urandom);
        req_wdata = {$urandom, $urandom};
        req_rw    = 4'($urandom);
        if (drop) req[owner] = 1'b0;
        for (int k = 0; k <= D; k++) begin
            exp_byte = (k == 0) ? {f_rw[owner], f_addr[owner]} : f_wdata[owner][(D-k)*8 +: 8];
            repeat ($urandom_range(0, 2)) tick();
            n_cmp++;
            if ({spi_empty, spi_data} !== {1'b0, exp_byte}) begin
                n_fail++;
                $display("[TB] FAIL tx_byte%0d: got empty=%b data=%h expected empty=0 data=%h",
                         k, spi_empty, spi_data, exp_byte);
            end
            spi_rdreq = 1'b1;
            if (overlap && k > 0) begin
                spi_rx_valid = 1'b1;
                spi_rx_byte  = rx_all[(D-k+1)*8 +: 8];
            end
            tick();
            spi_rdreq    = 1'b0;
            spi_rx_valid = 1'b0;
        end
        n_cmp++;
        if (spi_empty !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL empty_after_tx: got %b expected 1", spi_empty);
        end
        j0 = overlap ? D : 0;
        for (int j = j0; j <= D; j++) begin
            repeat ($urandom_range(0, 2)) tick();
            n_cmp++;
            if (done !== '0) begin
                n_fail++;
                $display("[TB] FAIL early_done: got %b expected 0000", done);
            end
            spi_rx_valid = 1'b1;
            spi_rx_byte  = rx_all[(D-j)*8 +: 8];
            tick();
            spi_rx_valid = 1'b0;
        end
        n_cmp++;
        if ({done, err, gnt, rdata} !== {exp_g, 1'b0, {N{1'b0}}, rx_all[DW-1:0]}) begin
            n_fail++;
            $display("[TB] FAIL completion: got done=%b err=%b gnt=%b rdata=%h expected done=%b err=0 gnt=0000 rdata=%h",
                     done, err, gnt, rdata, exp_g, rx_all[DW-1:0]);
        end
        exp_rdata  = rx_all[DW-1:0];
        req[owner] = 1'b0;
        tick();
        n_cmp++;
        if (done !== '0) begin
            n_fail++;
            $display("[TB] FAIL done_pulse: got %b expected 0000 one cycle later", done);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        n_cmp++;
        if ({gnt, done, err} !== {{N{1'b0}}, {N{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_ctl: got gnt=%b done=%b err=%b expected zeros", gnt, done, err);
        end
        n_cmp++;
        if ({rdata, spi_data} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got rdata=%h spi_data=%h expected 0", rdata, spi_data);
        end
        n_cmp++;
        if ({busy, spi_empty} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got busy=%b empty=%b expected busy=0 empty=1", busy, spi_empty);
        end
        tick();
        n_rst     = 1'b1;
        model_ptr = 0;
        exp_rdata = '0;
        tick();
    endtask

    task automatic test_single_write();
        int w; bit e;
        randomize_fields();
        f_rw[0]    = 1'b0;
        f_addr[0]  = 7'h15;
        f_wdata[0] = 16'hA55A;
        req        = 4'b0001;
        run_frame(pick(req, model_ptr), 24'($urandom), 1'b0, 1'b0, w, e);
        settle();
    endtask

    task automatic test_single_read();
        int w; bit e;
        randomize_fields();
        f_rw[2]   = 1'b1;
        f_addr[2] = 7'h03;
        req       = 4'b0100;
        run_frame(pick(req, model_ptr), 24'hFF1234, 1'b1, 1'b0, w, e);
        n_cmp++;
        if (rdata !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL read_hold: got rdata=%h expected 1234", rdata);
        end
        settle();
    endtask

    task automatic test_random_frames();
        logic [N-1:0] mask;
        int owner, w; bit e;
        for (int r = 0; r < 6; r++) begin
            randomize_fields();
            mask = 4'($urandom_range(1, 15));
            req  = mask;
            while (mask != '0) begin
                owner = pick(mask, model_ptr);
                run_frame(owner, 24'($urandom), 1'($urandom), 1'($urandom), w, e);
                mask[owner] = 1'b0;
                req         = mask;
            end
            settle();
        end
    endtask

    task automatic test_contention();
        int order[5] = '{0, 1, 2, 3, 0};
        int w; bit e;
        n_rst = 1'b0;
        tick();
        n_rst     = 1'b1;
        model_ptr = 0;
        exp_rdata = '0;
        randomize_fields();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            run_frame(order[f], 24'($urandom), 1'($urandom), 1'b0, w, e);
            req = (f == 4) ? 4'b0000 : 4'b1111;
            if (f > 0) begin
                n_cmp++;
                if (!e || (w + 1) < GAP + 2) begin
                    n_fail++;
                    $display("[TB] FAIL gap%0d: got %0d idle cycles empty_ok=%b expected >=%0d with empty high",
                             f, w + 1, e, GAP + 2);
                end
            end
        end
        settle();
    endtask

    task automatic test_timeout();
        logic [N-1:0] exp_g;
        int owner, w, cnt; bit e;
        randomize_fields();
        req   = 4'b1010;
        owner = pick(req, model_ptr);
        exp_g = '0;
        exp_g[owner] = 1'b1;
        load_fields();
        wait_grant(owner, w, e);
        cnt = 0;
        while (done === '0 && cnt < 400) begin
            tick();
            cnt++;
        end
        n_cmp++;
        if (cnt < TMO - 2 || cnt > TMO + 2) begin
            n_fail++;
            $display("[TB] FAIL timeout_delay: got %0d cycles expected about %0d", cnt, TMO);
        end
        n_cmp++;
        if ({done, err, gnt, spi_empty, rdata} !== {exp_g, 1'b1, {N{1'b0}}, 1'b1, exp_rdata}) begin
            n_fail++;
            $display("[TB] FAIL timeout_status: got done=%b err=%b gnt=%b empty=%b rdata=%h expected done=%b err=1 gnt=0000 empty=1 rdata=%h",
                     done, err, gnt, spi_empty, rdata, exp_g, exp_rdata);
        end
        req[owner] = 1'b0;
        tick();
        run_frame(pick(req, model_ptr), 24'($urandom), 1'b0, 1'b0, w, e);
        req = '0;
        settle();
    endtask

    task automatic test_reset_mid_frame();
        int w; bit e;
        randomize_fields();
        req = 4'b0001;
        load_fields();
        wait_grant(pick(req, model_ptr), w, e);
        spi_rdreq = 1'b1;
        tick();
        spi_rdreq = 1'b0;
        req       = 4'b1001;
        #2;
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, done, err, busy, spi_empty, spi_data, rdata} !==
            {{N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0, 1'b1, 8'h00, {DW{1'b0}}}) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_frame: got gnt=%b done=%b err=%b busy=%b empty=%b data=%h rdata=%h expected reset values",
                     gnt, done, err, busy, spi_empty, spi_data, rdata);
        end
        model_ptr = 0;
        exp_rdata = '0;
        tick();
        n_rst = 1'b1;
        run_frame(pick(req, model_ptr), 24'($urandom), 1'b1, 1'b0, w, e);
        req = '0;
        settle();
    endtask

    task automatic test_stray();
        int w; bit e;
        req = '0;
        for (int s = 0; s < 4; s++) begin
            spi_rdreq    = 1'b1;
            spi_rx_valid = 1'b1;
            spi_rx_byte  = 8'($urandom);
            tick();
            n_cmp++;
            if ({busy, done, gnt, spi_empty} !== {1'b0, {N{1'b0}}, {N{1'b0}}, 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL stray%0d: got busy=%b done=%b gnt=%b empty=%b expected idle",
                         s, busy, done, gnt, spi_empty);
            end
        end
        spi_rdreq    = 1'b0;
        spi_rx_valid = 1'b0;
        tick();
        randomize_fields();
        req = 4'b0010;
        run_frame(pick(req, model_ptr), 24'($urandom), 1'b0, 1'b0, w, e);
        settle();
    endtask

    initial begin
        n_rst        = 1'b0;
        req          = '0;
        req_rw       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        spi_rdreq    = 1'b0;
        spi_rx_byte  = '0;
        spi_rx_valid = 1'b0;
        test_reset();
        test_single_write();
        test_single_read();
        test_random_frames();
        test_contention();
        test_timeout();
        test_reset_mid_frame();
        test_stray();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_arbiter.md
Name: spi_frame_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one byte-oriented SPI master engine between NUM_REQ register-access requesters.
- Serialises each granted request into one SPI frame (1 instruction byte + DATA_BYTES data bytes) through a show-ahead FIFO-style source interface.
- Collects the returned bytes and hands read data plus completion status back to the owning requester.
- Sits between the control-plane register clients and the SPI master byte engine, which is configured with BYTES_PER_FRAME = DATA_BYTES+1.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BYTES, 2, data bytes per frame after the instruction byte (1..4).
- GAP_CYCLES, 2, sys_clk cycles spi_empty is held high between frames so the engine closes chip-select.
- TIMEOUT, 255, idle cycles without engine activity before a frame is aborted (8-bit counter).

Ports:
- sys_clk, in, 1, clock; all logic is on posedge.
- n_rst, in, 1, asynchronous active-low reset.
- req, in, NUM_REQ, per-requester request; held high until the matching done.
- req_rw, in, NUM_REQ, 1 = read, 0 = write.
- req_addr, in, NUM_REQ*7, register address, requester i at [7i+6:7i].
- req_wdata, in, NUM_REQ*DATA_BYTES*8, write data, MSB byte sent first.
- gnt, out, NUM_REQ, one-hot; high from grant until done.
- done, out, NUM_REQ, one-cycle completion pulse to the owner.
- err, out, 1, valid with done; 1 = timeout abort.
- rdata, out, DATA_BYTES*8, read-back data; valid with done and held until the next done.
- busy, out, 1, high when not IDLE.
- spi_data, out, 8, byte presented to the engine.
- spi_empty, out, 1, low while bytes are pending.
- spi_rdreq, in, 1, engine consumed spi_data; advance to the next byte.
- spi_rx_byte, in, 8, byte received from the engine.
- spi_rx_valid, in, 1, one-cycle strobe for spi_rx_byte.

Behaviour:
- Reset values: gnt=0, done=0, err=0, rdata=0, busy=0, spi_empty=1, spi_data=0. State=IDLE, rr_ptr=0, all counters=0.
- States:
  - IDLE: if any req bit is set, go to ARB.
  - ARB (1 cycle): pick the first set req starting at index rr_ptr, wrapping modulo NUM_REQ. Latch rw, addr and wdata into shadow registers. Set gnt one-hot. Set rr_ptr = winner+1 (wraps). Set byte_idx=0. Go to SEND.
  - SEND: spi_empty=0.
    - spi_data = {rw, addr} when byte_idx=0, otherwise wdata byte (byte_idx-1), MSB byte first.
    - On spi_rdreq: byte_idx+1. When the consumed byte is byte_idx==DATA_BYTES, set spi_empty=1 the next cycle and go to WAIT_RX.
  - WAIT_RX: spi_empty=1. Count spi_rx_valid strobes (rx_cnt counts across SEND and WAIT_RX, since the first strobes can arrive during SEND).
    - The strobe for byte 0 is discarded.
    - Bytes 1..DATA_BYTES shift into rdata MSB-first.
    - When rx_cnt reaches DATA_BYTES+1, go to DONE.
  - DONE (1 cycle): done[owner]=1, err latched, gnt cleared. Go to GAP.
  - GAP: spi_empty=1 for GAP_CYCLES cycles, then go to IDLE.
- Writes also capture rdata; the value returned is whatever the device drove.
- Latency: ARB is 1 cycle after req is seen in IDLE. done comes 1 cycle after the final spi_rx_valid. Back-to-back grants are separated by at least GAP_CYCLES+2 cycles.
- Timeout:
  - The counter runs in SEND and WAIT_RX and clears on any spi_rdreq or spi_rx_valid.
  - When it reaches TIMEOUT, go to DONE with err=1. rdata keeps its previous value. spi_empty goes high immediately.
- Boundary conditions:
  - spi_rdreq outside SEND is ignored.
  - spi_rx_valid outside SEND/WAIT_RX is ignored.
  - req dropped mid-frame: the frame still completes and done still pulses.
  - A new req during SEND..GAP waits for the next ARB.
  - Simultaneous spi_rdreq and spi_rx_valid: both are processed in the same cycle.
  - NUM_REQ=1 degenerates to sequential service.
  - Reset mid-frame returns everything to reset values at once; any partial frame is abandoned and the engine ends it via spi_empty=1.

Decomposition:
- Shared package spi_ctrl_pkg holds:
  - the state enum (IDLE, ARB, SEND, WAIT_RX, DONE, GAP);
  - INSTR_RW_BIT=7;
  - ADDR_W=7.
- One sub-module, rr_arbiter: combinational round-robin pick with inputs req and rr_ptr and a one-hot output. It is reused by other shared-bus controllers.

Test Plan:
- Single write: req[0], rw=0, addr=0x15, wdata=0xA55A, 3 rdreqs then 3 rx strobes → spi_data sequence 0x15, 0xA5, 0x5A. done[0] one pulse, err=0.
- Single read: req[2], rw=1, addr=0x03, rx bytes 0xFF, 0x12, 0x34 → first spi_data 0x83, rdata=0x1234 at done[2].
- Contention: req=4'b1111 held, rr_ptr=0 → grant order 0,1,2,3,0. Between frames spi_empty stays high for ≥GAP_CYCLES.
- Timeout: grant, then no spi_rdreq for 255 cycles → done pulse with err=1, spi_empty=1, rdata unchanged, next requester served.
- Reset mid-SEND after the 1st rdreq → all outputs return to reset values the same cycle. A fresh req afterwards is served from rr_ptr=0.
- Stray strobes: spi_rdreq and spi_rx_valid pulsed in IDLE → no state change, no done.
